// File: rtl/mem_arbiter.sv
// 2:1 arbiter sharing one memory port between instruction fetch and the data (write-buffer) port.
// One request per port is captured; one downstream transaction is in flight at a time.
module mem_arbiter #(
  parameter bit round_robin = 1'b1
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        imem_valid,
  input  logic        imem_fence,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  input  logic [3:0]  imem_wstrb,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic        dmem_fence,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        mem_valid,
  output logic        mem_fence,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t      state;
  logic        pend_i;
  logic        pend_d;
  logic        last_grant;
  logic        i_fence;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic        d_fence;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        grant_d;

  // last_grant: 1 = data port. On a tie the data port wins unless round robin says it went last.
  always_comb begin
    grant_d = pend_d & (~pend_i | ~round_robin | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pend_i     <= 1'b0;
      pend_d     <= 1'b0;
      last_grant <= 1'b0;
      i_fence    <= 1'b0;
      i_addr     <= '0;
      i_wdata    <= '0;
      i_wstrb    <= '0;
      d_fence    <= 1'b0;
      d_addr     <= '0;
      d_wdata    <= '0;
      d_wstrb    <= '0;
      mem_valid  <= 1'b0;
      mem_fence  <= 1'b0;
      mem_instr  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      // A pending port is busy (including its ready cycle), so a held valid never re-captures.
      if (imem_valid && !pend_i) begin
        pend_i  <= 1'b1;
        i_fence <= imem_fence;
        i_addr  <= imem_addr;
        i_wdata <= imem_wdata;
        i_wstrb <= imem_wstrb;
      end
      if (dmem_valid && !pend_d) begin
        pend_d  <= 1'b1;
        d_fence <= dmem_fence;
        d_addr  <= dmem_addr;
        d_wdata <= dmem_wdata;
        d_wstrb <= dmem_wstrb;
      end

      unique case (state)
        IDLE: begin
          if (pend_i || pend_d) begin
            mem_valid  <= 1'b1;
            last_grant <= grant_d;
            if (grant_d) begin
              state     <= BUSY_D;
              mem_instr <= 1'b0;
              mem_fence <= d_fence;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_wstrb;
            end else begin
              state     <= BUSY_I;
              mem_instr <= 1'b1;
              mem_fence <= i_fence;
              mem_addr  <= i_addr;
              mem_wdata <= i_wdata;
              mem_wstrb <= i_wstrb;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          mem_valid <= 1'b0;
          if (mem_ready) begin
            if (state == BUSY_I) pend_i <= 1'b0;
            else                 pend_d <= 1'b0;
            state     <= IDLE;
            mem_fence <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Responses go only to the owner; a fence carries no read data.
  always_comb begin
    imem_ready = mem_ready & (state == BUSY_I);
    dmem_ready = mem_ready & (state == BUSY_D);
    imem_rdata = (state == BUSY_I && !mem_fence) ? mem_rdata : '0;
    dmem_rdata = (state == BUSY_D && !mem_fence) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin and fixed-priority instances share stimulus,
// cycle tables check the common behaviour and hand sequences check grant ordering.
module tb_mem_arbiter;

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic        df;
    logic [31:0] da;
    logic [31:0] dw;
    logic [3:0]  ds;
    logic        mr;
    logic [31:0] md;
  } in_t;

  typedef struct packed {
    logic        v;
    logic        ins;
    logic        f;
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  s;
    logic        ir;
    logic [31:0] id;
    logic        dr;
    logic [31:0] dd;
  } exp_t;

  typedef struct {
    string name;
    in_t   stim;
    exp_t  want;
  } vec_t;

  logic        rst, clk;
  logic        imem_valid, imem_fence, dmem_valid, dmem_fence, mem_ready;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata, mem_rdata;
  logic [3:0]  imem_wstrb, dmem_wstrb;

  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic        imem_ready, dmem_ready, mem_valid, mem_fence, mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] fp_imem_rdata, fp_dmem_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_imem_ready, fp_dmem_ready, fp_mem_valid, fp_mem_fence, fp_mem_instr;
  logic [3:0]  fp_mem_wstrb;

  int applied = 0;
  int miscompares = 0;
  vec_t vecs[$];

  mem_arbiter #(.round_robin(1'b1)) dut_rr (
    .rst(rst), .clk(clk),
    .imem_valid(imem_valid), .imem_fence(imem_fence), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_fence(dmem_fence), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_valid(mem_valid), .mem_fence(mem_fence), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_arbiter #(.round_robin(1'b0)) dut_fp (
    .rst(rst), .clk(clk),
    .imem_valid(imem_valid), .imem_fence(imem_fence), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb),
    .imem_rdata(fp_imem_rdata), .imem_ready(fp_imem_ready),
    .dmem_valid(dmem_valid), .dmem_fence(dmem_fence), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(fp_dmem_rdata), .dmem_ready(fp_dmem_ready),
    .mem_valid(fp_mem_valid), .mem_fence(fp_mem_fence), .mem_instr(fp_mem_instr),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wstrb(fp_mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic in_t mk_in(logic r, logic iv, logic [31:0] ia, logic dv, logic df,
                                logic [31:0] da, logic [31:0] dw, logic [3:0] ds,
                                logic mr, logic [31:0] md);
    mk_in = '{rst: r, iv: iv, ia: ia, dv: dv, df: df, da: da, dw: dw, ds: ds, mr: mr, md: md};
  endfunction

  function automatic exp_t mk_exp(logic v, logic ins, logic f, logic [31:0] a, logic [31:0] w,
                                  logic [3:0] s, logic ir, logic [31:0] id, logic dr, logic [31:0] dd);
    mk_exp = '{v: v, ins: ins, f: f, a: a, w: w, s: s, ir: ir, id: id, dr: dr, dd: dd};
  endfunction

  function automatic in_t resp(logic [31:0] md);
    resp = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 1, md);
  endfunction

  function automatic exp_t actual_rr();
    actual_rr = mk_exp(mem_valid, mem_instr, mem_fence, mem_addr, mem_wdata, mem_wstrb,
                       imem_ready, imem_rdata, dmem_ready, dmem_rdata);
  endfunction

  function automatic exp_t actual_fp();
    actual_fp = mk_exp(fp_mem_valid, fp_mem_instr, fp_mem_fence, fp_mem_addr, fp_mem_wdata,
                       fp_mem_wstrb, fp_imem_ready, fp_imem_rdata, fp_dmem_ready, fp_dmem_rdata);
  endfunction

  task automatic add(input string name, input in_t s, input exp_t e);
    vec_t t;
    t.name = name;
    t.stim = s;
    t.want = e;
    vecs.push_back(t);
  endtask

  task automatic apply_stimulus(input in_t s);
    rst        = s.rst;
    imem_valid = s.iv;
    imem_addr  = s.ia;
    dmem_valid = s.dv;
    dmem_fence = s.df;
    dmem_addr  = s.da;
    dmem_wdata = s.dw;
    dmem_wstrb = s.ds;
    mem_ready  = s.mr;
    mem_rdata  = s.md;
  endtask

  task automatic check_output(input string name, input exp_t got, input exp_t want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got v=%b i=%b f=%b a=%h w=%h s=%h ir=%b id=%h dr=%b dd=%h, want v=%b i=%b f=%b a=%h w=%h s=%h ir=%b id=%h dr=%b dd=%h",
               name, got.v, got.ins, got.f, got.a, got.w, got.s, got.ir, got.id, got.dr, got.dd,
               want.v, want.ins, want.f, want.a, want.w, want.s, want.ir, want.id, want.dr, want.dd);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  // Waits (bounded) for a request pulse, reports which port each instance issued, then acks it.
  task automatic serve_one(input string name, input logic [31:0] data,
                           output logic got_rr, output logic got_fp);
    bit ok = 0;
    got_rr = 1'bx;
    got_fp = 1'bx;
    for (int c = 0; c < 12 && !ok; c++) begin
      @(negedge clk);
      if (mem_valid === 1'b1) begin
        ok = 1;
        got_rr = mem_instr;
        got_fp = fp_mem_instr;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      mem_ready = 1'b1;
      mem_rdata = data;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
    end else begin
      applied++;
      miscompares++;
      $display("[TB] FAIL %s timeout: got no mem_valid, want pulse within 12 cycles", name);
    end
  endtask

  initial begin
    in_t  idle, st, fr;
    exp_t zero, held;
    logic g_rr, g_fp;

    idle = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    zero = '0;

    add("t1 reset state", idle, zero);
    add("t1 req", mk_in(1, 0, 0, 1, 0, 32'h0000_1000, 0, 4'h0, 0, 0), zero);
    add("t1 decide", idle, zero);
    add("t1 issue", idle, mk_exp(1, 0, 0, 32'h0000_1000, 0, 0, 0, 0, 0, 0));
    add("t1 resp", resp(32'hDEAD_BEEF), mk_exp(0, 0, 0, 32'h0000_1000, 0, 0, 0, 0, 1, 32'hDEAD_BEEF));
    add("t1 done", idle, zero);
    add("t1 stray ready", resp(32'h0000_0055), zero);
    add("t1 after stray", idle, zero);

    add("t2 reset", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), zero);
    add("t2 both req", mk_in(1, 1, 32'h100, 1, 0, 32'h200, 0, 0, 0, 0), zero);
    add("t2 decide", idle, zero);
    add("t2 d issue", idle, mk_exp(1, 0, 0, 32'h200, 0, 0, 0, 0, 0, 0));
    add("t2 d resp", resp(32'h0000_0200), mk_exp(0, 0, 0, 32'h200, 0, 0, 0, 0, 1, 32'h0000_0200));
    add("t2 gap", idle, zero);
    add("t2 i issue", idle, mk_exp(1, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0));
    add("t2 i resp", resp(32'h1111_0100), mk_exp(0, 1, 0, 32'h100, 0, 0, 1, 32'h1111_0100, 0, 0));
    add("t2 done", idle, zero);

    st   = mk_in(1, 0, 0, 1, 0, 32'h2004, 32'h1234_5678, 4'hF, 0, 0);
    held = mk_exp(0, 0, 0, 32'h2004, 32'h1234_5678, 4'hF, 0, 0, 0, 0);
    add("t4 valid c0", st, zero);
    add("t4 valid c1", st, zero);
    add("t4 valid c2 issue", st, mk_exp(1, 0, 0, 32'h2004, 32'h1234_5678, 4'hF, 0, 0, 0, 0));
    add("t4 valid c3", st, held);
    add("t4 valid c4", st, held);
    add("t4 wait", idle, held);
    add("t4 resp", resp(32'h0000_9999), mk_exp(0, 0, 0, 32'h2004, 32'h1234_5678, 4'hF, 0, 0, 1, 32'h0000_9999));
    add("t4 done", idle, zero);
    add("t4 no repeat", idle, zero);

    fr = mk_in(1, 0, 0, 1, 1, 32'h3000, 0, 0, 0, 0);
    add("t5 req", fr, zero);
    add("t5 decide", idle, zero);
    add("t5 issue", idle, mk_exp(1, 0, 1, 32'h3000, 0, 0, 0, 0, 0, 0));
    add("t5 hold", idle, mk_exp(0, 0, 1, 32'h3000, 0, 0, 0, 0, 0, 0));
    add("t5 resp", resp(32'hCAFE_F00D), mk_exp(0, 0, 1, 32'h3000, 0, 0, 0, 0, 1, 0));
    add("t5 done", idle, zero);

    add("t6 i req", mk_in(1, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0), zero);
    add("t6 d req", mk_in(1, 0, 0, 1, 0, 32'h400, 0, 0, 0, 0), zero);
    add("t6 i issue", idle, mk_exp(1, 1, 0, 32'h300, 0, 0, 0, 0, 0, 0));
    add("t6 reset", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_exp(0, 1, 0, 32'h300, 0, 0, 0, 0, 0, 0));
    add("t6 late ready", resp(32'h0000_0077), zero);
    add("t6 no grant", idle, zero);
    add("t6 still idle", idle, zero);
    add("t6 fresh req", mk_in(1, 0, 0, 1, 0, 32'h500, 0, 0, 0, 0), zero);
    add("t6 decide", idle, zero);
    add("t6 issue", idle, mk_exp(1, 0, 0, 32'h500, 0, 0, 0, 0, 0, 0));
    add("t6 resp", resp(32'h0000_ABCD), mk_exp(0, 0, 0, 32'h500, 0, 0, 0, 0, 1, 32'h0000_ABCD));
    add("t6 done", idle, zero);

    imem_fence = 1'b0;
    imem_wdata = '0;
    imem_wstrb = '0;
    apply_stimulus(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      apply_stimulus(vecs[k].stim);
      @(negedge clk);
      check_output({vecs[k].name, " rr"}, actual_rr(), vecs[k].want);
      check_output({vecs[k].name, " fp"}, actual_fp(), vecs[k].want);
      @(posedge clk); #1;
    end

    // Continuous requests from both ports: both policies alternate D,I,... since a finished port
    // cannot re-capture in its ready cycle and so is never pending at the next decision.
    apply_stimulus(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    apply_stimulus(mk_in(1, 1, 32'h600, 1, 0, 32'h700, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++) begin
      serve_one($sformatf("t3 grant%0d", k), 32'h0, g_rr, g_fp);
      check_bit($sformatf("t3 rr grant%0d instr", k), g_rr, k[0]);
      check_bit($sformatf("t3 fp grant%0d instr", k), g_fp, k[0]);
    end
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    serve_one("t3 drain", 32'h0, g_rr, g_fp);
    check_bit("t3 rr drain instr", g_rr, 1'b0);
    check_bit("t3 fp drain instr", g_fp, 1'b0);

    // Fresh tie after a data grant: round robin picks fetch, fixed priority picks data.
    imem_valid = 1'b1;
    dmem_valid = 1'b1;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    serve_one("t3 tie first", 32'h0, g_rr, g_fp);
    check_bit("t3 rr tie first instr", g_rr, 1'b1);
    check_bit("t3 fp tie first instr", g_fp, 1'b0);
    serve_one("t3 tie second", 32'h0, g_rr, g_fp);
    check_bit("t3 rr tie second instr", g_rr, 1'b0);
    check_bit("t3 fp tie second instr", g_fp, 1'b1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
